// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Define SERIAL_RX_PARITY_EN to add the parity bit and its check.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              last_bit;
  logic              parity_ok;
  logic              deliver;
  logic              stop_err;
  logic              consume;

`ifdef SERIAL_RX_PARITY_EN
  logic              parity_bit;

  // Even parity: data bits XOR the received parity bit must be zero.
  assign parity_ok = ~(^{shift_reg, parity_bit});
`else
  assign parity_ok = 1'b1;
`endif

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign consume  = data_valid & out_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    deliver    = 1'b0;
    stop_err   = 1'b0;
    case (state)
      IDLE: begin
        if (!din) state_next = DATA;
      end
      DATA: begin
        if (last_bit) begin
`ifdef SERIAL_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        state_next = STOP;
      end
`endif
      STOP: begin
        if (din && parity_ok) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end else begin
          stop_err   = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (din) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA) begin
        shift_reg[bit_cnt] <= din;
        bit_cnt            <= bit_cnt + 1'b1;
      end
`ifdef SERIAL_RX_PARITY_EN
      if (state == PARITY) parity_bit <= din;
`endif
    end
  end

  // A consume on the same edge as a delivery frees the holding register, so no overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_err;
      overrun   <= 1'b0;
      if (deliver) begin
        if (data_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end
      end else if (consume) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx with a frame-level reference model.
// Honours SERIAL_RX_PARITY_EN the same way as the design.
module tb_serial_frame_rx;

  localparam int DATA_W = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif

  logic              clk;
  logic              rst;
  logic              din;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: collects bits of a frame after a start bit, judges the frame as a whole.
  int                m_mode;
  logic              m_bits[$];
  logic [DATA_W-1:0] m_word;
  logic              m_valid;
  logic              m_ferr;
  logic              m_ovr;

  serial_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update();
    logic              deliver;
    logic              x;
    logic [DATA_W-1:0] w;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    deliver = 1'b0;
    w       = '0;
    if (rst) begin
      m_mode = 0;
      m_bits.delete();
      m_word  = '0;
      m_valid = 1'b0;
      return;
    end
    case (m_mode)
      0: if (din == 1'b0) begin m_mode = 1; m_bits.delete(); end
      1: begin
        m_bits.push_back(din);
        if (m_bits.size() == DATA_W + PW + 1) begin
          x = 1'b0;
          for (int i = 0; i < DATA_W + PW; i++) x ^= m_bits[i];
          for (int i = 0; i < DATA_W; i++) w[i] = m_bits[i];
          if (m_bits[DATA_W + PW] == 1'b1 && (PW == 0 || x == 1'b0)) begin
            deliver = 1'b1;
            m_mode  = 0;
          end else begin
            m_ferr = 1'b1;
            m_mode = 2;
          end
        end
      end
      default: if (din == 1'b1) m_mode = 0;
    endcase
    if (deliver) begin
      if (m_valid && !out_ready) m_ovr = 1'b1;
      else begin m_word = w; m_valid = 1'b1; end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input logic b, input logic r, input logic rs);
    @(negedge clk);
    din       = b;
    out_ready = r;
    rst       = rs;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop_bit,
                            input logic par_flip, input logic r_data, input logic r_stop);
    drive(1'b0, r_data, 1'b0);
    for (int i = 0; i < DATA_W; i++) drive(word[i], r_data, 1'b0);
    if (PW == 1) drive((^word) ^ par_flip, r_data, 1'b0);
    drive(stop_bit, r_stop, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(1'($urandom), 1'($urandom), 1'b1);
    n_tests++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", data_out); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", data_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_single_frame();
    logic [DATA_W-1:0] w;
    w = 8'h9A;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DATA_W; i++) drive(w[i], 1'b1, 1'b0);
    if (PW == 1) drive(^w, 1'b1, 1'b0);
    n_tests++; if (data_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_early valid=%b busy=%b exp valid=0 busy=1", data_valid, busy);
    end
    drive(1'b1, 1'b1, 1'b0);
    n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", data_valid); end
    n_tests++; if (data_out !== 8'h9A) begin n_fail++; $display("FAIL single_data got %h exp 9a", data_out); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b exp 0", busy); end
    drive(1'b1, 1'b1, 1'b0);
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL single_onecycle got %b exp 0", data_valid); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_ovr got %b exp 1", overrun); end
    n_tests++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL b2b_hold got %h exp 3c", data_out); end
    n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b exp 1", data_valid); end
    drive(1'b1, 1'b0, 1'b0);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr_pulse got %b exp 0", overrun); end
    n_tests++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL b2b_stable got %h exp 3c", data_out); end
    drive(1'b1, 1'b1, 1'b0);
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consume got %b exp 0", data_valid); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse got %b exp 1", frame_err); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid got %b exp 0", data_valid); end
    drive(1'b0, 1'b1, 1'b0);
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_onecycle got %b exp 0", frame_err); end
    drive(1'b0, 1'b1, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait got %b exp 1", busy); end
    drive(1'b1, 1'b1, 1'b0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle got %b exp 0", busy); end
    send_frame(8'h12, 1'b1, 1'b0, 1'b1, 1'b1);
    n_tests++; if (data_valid !== 1'b1 || data_out !== 8'h12) begin
      n_fail++; $display("FAIL ferr_recover got valid=%b data=%h exp valid=1 data=12", data_valid, data_out);
    end
    drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    send_frame(8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hB4, 1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++; if (data_out !== 8'hB4) begin n_fail++; $display("FAIL simul_data got %h exp b4", data_out); end
    n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid got %b exp 1", data_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL simul_ovr got %b exp 0", overrun); end
    drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    n_tests++; if (data_valid !== 1'b1 || data_out !== 8'h07) begin
      n_fail++; $display("FAIL parity_good got valid=%b data=%h exp valid=1 data=07", data_valid, data_out);
    end
    drive(1'b1, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++; if (frame_err !== 1'b1 || data_valid !== 1'b0) begin
      n_fail++; $display("FAIL parity_bad got ferr=%b valid=%b exp ferr=1 valid=0", frame_err, data_valid);
    end
    drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] w;
    w = 8'hA5;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(w[i], 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    n_tests++; if (busy !== 1'b0 || data_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || data_out !== '0) begin
      n_fail++; $display("FAIL rstmid_outs got busy=%b valid=%b ferr=%b ovr=%b data=%h exp all 0",
                         busy, data_valid, frame_err, overrun, data_out);
    end
    send_frame(w, 1'b1, 1'b0, 1'b1, 1'b1);
    n_tests++; if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
      n_fail++; $display("FAIL rstmid_frame got valid=%b data=%h exp valid=1 data=a5", data_valid, data_out);
    end
    drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic              q[$];
    logic [DATA_W-1:0] w;
    int                errs;
    while (q.size() < 2000) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) q.push_back(1'($urandom));
      end else begin
        w = DATA_W'($urandom);
        q.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) q.push_back(w[i]);
        if (PW == 1) q.push_back((^w) ^ ($urandom_range(0, 7) == 0));
        q.push_back($urandom_range(0, 7) != 0);
      end
    end
    errs = 0;
    foreach (q[k]) begin
      drive(q[k], 1'($urandom), 1'b0);
      n_tests++; if (data_valid !== m_valid) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_valid cyc %0d got %b exp %b", k, data_valid, m_valid); end
      n_tests++; if (data_out !== m_word) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_data cyc %0d got %h exp %h", k, data_out, m_word); end
      n_tests++; if (frame_err !== m_ferr) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_ferr cyc %0d got %b exp %b", k, frame_err, m_ferr); end
      n_tests++; if (overrun !== m_ovr) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_ovr cyc %0d got %b exp %b", k, overrun, m_ovr); end
      n_tests++; if (busy !== (m_mode != 0)) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_busy cyc %0d got %b exp %b", k, busy, m_mode != 0); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    din       = 1'b1;
    out_ready = 1'b0;
    m_mode    = 0;
    m_word    = '0;
    m_valid   = 1'b0;
    m_ferr    = 1'b0;
    m_ovr     = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_err();
    test_simultaneous();
    if (PW == 1) test_parity();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
